// File: rtl/player_health.sv
// Player health tracker: applies hits, pickups and timed regeneration, and
// drives the blood bar, invulnerability window and death flag.
module player_health #(
  parameter int MaxBlood    = 400,
  parameter int InvFrames   = 30,
  parameter int RegenDelay  = 120,
  parameter int RegenPeriod = 8,
  parameter int RegenStep   = 1,
  parameter int HealAmount  = 100
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Frame_Tick,
  input  logic       Game_Start,
  input  logic       Hit,
  input  logic [7:0] Hit_Damage,
  input  logic       Heal,
  output logic [9:0] Player_Blood,
  output logic       Is_Dead,
  output logic       Invincible,
  output logic       Hurt_Flash
);

  localparam int IW = ($clog2(InvFrames + 1) > 5) ? $clog2(InvFrames + 1) : 5;
  localparam int QW = ($clog2(RegenDelay + 1) > 1) ? $clog2(RegenDelay + 1) : 1;
  localparam int RW = ($clog2(RegenPeriod) > 1) ? $clog2(RegenPeriod) : 1;

  localparam logic [10:0]   MaxB      = 11'(MaxBlood);
  localparam logic [10:0]   HealA     = 11'(HealAmount);
  localparam logic [10:0]   RegenS    = 11'(RegenStep);
  localparam logic [IW-1:0] InvMax    = IW'(InvFrames);
  localparam logic [QW-1:0] QuietMax  = QW'(RegenDelay);
  localparam logic [RW-1:0] RegenLast = RW'(RegenPeriod - 1);

  typedef enum logic [1:0] {ALIVE, HURT, DEAD} state_t;

  state_t        r_state, w_nextState;
  logic [9:0]    r_blood, w_nextBlood;
  logic [IW-1:0] r_invCnt, w_nextInvCnt;
  logic [QW-1:0] r_quietCnt, w_nextQuietCnt;
  logic [RW-1:0] r_regenCnt, w_nextRegenCnt;

  logic [10:0] w_diff, w_afterHit, w_healBase, w_healSum, w_healed;
  logic [10:0] w_regenSum, w_regenCapped;
  logic        w_hitAccept, w_fatal, w_healOk, w_regenActive, w_regenWrap;

  // Saturating arithmetic; a heal stacked on a same-cycle hit starts from the post-hit value.
  always_comb begin
    w_diff        = {1'b0, r_blood} - {3'b000, Hit_Damage};
    w_afterHit    = w_diff[10] ? 11'd0 : w_diff;
    w_hitAccept   = Hit && !Game_Start && (r_state == ALIVE);
    w_fatal       = (w_afterHit == 11'd0);
    w_healBase    = w_hitAccept ? w_afterHit : {1'b0, r_blood};
    w_healSum     = w_healBase + HealA;
    w_healed      = (w_healSum > MaxB) ? MaxB : w_healSum;
    w_healOk      = Heal && (r_state != DEAD);
    w_regenSum    = {1'b0, r_blood} + RegenS;
    w_regenCapped = (w_regenSum > MaxB) ? MaxB : w_regenSum;
    w_regenActive = Frame_Tick && (r_state == ALIVE) && (r_quietCnt == QuietMax);
    w_regenWrap   = w_regenActive && (r_regenCnt == RegenLast);
  end

  always_comb begin
    w_nextState = r_state;
    if (Game_Start) begin
      w_nextState = ALIVE;
    end else begin
      case (r_state)
        ALIVE:   if (w_hitAccept) w_nextState = w_fatal ? DEAD : HURT;
        HURT:    if (Frame_Tick && (r_invCnt == IW'(1))) w_nextState = ALIVE;
        DEAD:    w_nextState = DEAD;
        default: w_nextState = ALIVE;
      endcase
    end
  end

  // An accepted hit swallows any same-cycle frame tick; DEAD freezes everything.
  always_comb begin
    w_nextBlood    = r_blood;
    w_nextInvCnt   = r_invCnt;
    w_nextQuietCnt = r_quietCnt;
    w_nextRegenCnt = r_regenCnt;
    if (Game_Start) begin
      w_nextBlood    = MaxB[9:0];
      w_nextInvCnt   = '0;
      w_nextQuietCnt = '0;
      w_nextRegenCnt = '0;
    end else if (w_hitAccept) begin
      w_nextQuietCnt = '0;
      w_nextRegenCnt = '0;
      if (w_fatal) begin
        w_nextBlood = '0;
      end else begin
        w_nextBlood  = w_healOk ? w_healed[9:0] : w_afterHit[9:0];
        w_nextInvCnt = InvMax;
      end
    end else if (r_state != DEAD) begin
      if (Frame_Tick) begin
        if (r_quietCnt != QuietMax) w_nextQuietCnt = r_quietCnt + QW'(1);
        if (r_state == HURT) w_nextInvCnt = r_invCnt - IW'(1);
      end
      if (w_regenActive) w_nextRegenCnt = w_regenWrap ? '0 : r_regenCnt + RW'(1);
      if (w_healOk) begin
        w_nextBlood = w_healed[9:0];
      end else if (w_regenWrap) begin
        w_nextBlood = w_regenCapped[9:0];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= ALIVE;
      r_blood    <= MaxB[9:0];
      r_invCnt   <= '0;
      r_quietCnt <= '0;
      r_regenCnt <= '0;
    end else begin
      r_state    <= w_nextState;
      r_blood    <= w_nextBlood;
      r_invCnt   <= w_nextInvCnt;
      r_quietCnt <= w_nextQuietCnt;
      r_regenCnt <= w_nextRegenCnt;
    end
  end

  always_comb begin
    Player_Blood = r_blood;
    Is_Dead      = (r_state == DEAD);
    Invincible   = (r_state == HURT);
    Hurt_Flash   = (r_state == HURT) && r_invCnt[2];
  end

endmodule

// File: tb/tb_player_health.sv
// Directed, table-driven bench for player_health with default parameters,
// plus hand sequences for regeneration timing and asynchronous reset.
module tb_player_health;

  logic       clock;
  logic       reset;
  logic       frameTick;
  logic       gameStart;
  logic       hit;
  logic [7:0] hitDamage;
  logic       heal;
  logic [9:0] playerBlood;
  logic       isDead;
  logic       invincible;
  logic       hurtFlash;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic       hit;
    logic [7:0] dmg;
    logic       heal;
    logic       tick;
    logic       start;
    int         reps;
    int         expBlood;
    logic       expDead;
    logic       expInv;
    logic       expFlash;
  } vec_t;

  vec_t vecs[$];

  player_health dut (
    .Clk(clock),
    .Reset(reset),
    .Frame_Tick(frameTick),
    .Game_Start(gameStart),
    .Hit(hit),
    .Hit_Damage(hitDamage),
    .Heal(heal),
    .Player_Blood(playerBlood),
    .Is_Dead(isDead),
    .Invincible(invincible),
    .Hurt_Flash(hurtFlash)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int b, input logic d, input logic v, input logic f);
    checkOutput({tag, " blood"}, int'(playerBlood), b);
    checkOutput({tag, " dead"}, int'(isDead), int'(d));
    checkOutput({tag, " invincible"}, int'(invincible), int'(v));
    checkOutput({tag, " flash"}, int'(hurtFlash), int'(f));
  endtask

  // One clock of stimulus; outputs are then sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic h, input logic [7:0] d, input logic hl,
                               input logic t, input logic s);
    hit = h; hitDamage = d; heal = hl; frameTick = t; gameStart = s;
    @(posedge clock);
    #1;
    hit = 1'b0; hitDamage = 8'd0; heal = 1'b0; frameTick = 1'b0; gameStart = 1'b0;
  endtask

  task automatic addVec(input logic h, input int d, input logic hl, input logic t, input logic s,
                        input int reps, input int b, input logic dd, input logic v, input logic f);
    vec_t x;
    x.hit = h; x.dmg = 8'(d); x.heal = hl; x.tick = t; x.start = s; x.reps = reps;
    x.expBlood = b; x.expDead = dd; x.expInv = v; x.expFlash = f;
    vecs.push_back(x);
  endtask

  initial begin
    int expBlood;
    reset = 1'b0; frameTick = 1'b0; gameStart = 1'b0; hit = 1'b0; hitDamage = 8'd0; heal = 1'b0;

    //     hit dmg heal tick start reps blood dead inv flash
    addVec(0,   0,  0,   0,   0,    1,  400,  0,   0,  0);
    addVec(1,  50,  0,   0,   0,    1,  350,  0,   1,  1);
    addVec(1, 200,  0,   0,   0,    1,  350,  0,   1,  1);
    addVec(0,   0,  0,   1,   0,   29,  350,  0,   1,  0);
    addVec(0,   0,  0,   1,   0,    1,  350,  0,   0,  0);
    addVec(1, 255,  0,   0,   0,    1,   95,  0,   1,  1);
    addVec(0,   0,  0,   1,   0,   30,   95,  0,   0,  0);
    addVec(1,  65,  0,   0,   0,    1,   30,  0,   1,  1);
    addVec(0,   0,  0,   1,   0,   30,   30,  0,   0,  0);
    addVec(1, 255,  0,   0,   0,    1,    0,  1,   0,  0);
    addVec(0,   0,  1,   0,   0,    1,    0,  1,   0,  0);
    addVec(0,   0,  0,   1,   0,    5,    0,  1,   0,  0);
    addVec(0,   0,  0,   0,   1,    1,  400,  0,   0,  0);
    addVec(1,  20,  0,   0,   0,    1,  380,  0,   1,  1);
    addVec(0,   0,  0,   1,   0,   30,  380,  0,   0,  0);
    addVec(0,   0,  1,   0,   0,    1,  400,  0,   0,  0);
    addVec(1, 250,  0,   0,   0,    1,  150,  0,   1,  1);
    addVec(0,   0,  1,   0,   0,    1,  250,  0,   1,  1);
    addVec(0,   0,  0,   1,   0,   30,  250,  0,   0,  0);
    addVec(1, 150,  0,   0,   0,    1,  100,  0,   1,  1);
    addVec(0,   0,  0,   1,   0,   30,  100,  0,   0,  0);
    addVec(1,  40,  1,   0,   0,    1,  160,  0,   1,  1);
    addVec(0,   0,  0,   1,   0,   30,  160,  0,   0,  0);
    addVec(1, 120,  0,   0,   0,    1,   40,  0,   1,  1);
    addVec(0,   0,  0,   1,   0,   30,   40,  0,   0,  0);
    addVec(1,  40,  1,   0,   0,    1,    0,  1,   0,  0);
    addVec(1, 100,  0,   0,   1,    1,  400,  0,   0,  0);
    addVec(1,  10,  0,   1,   0,    1,  390,  0,   1,  1);
    addVec(0,   0,  0,   1,   0,   29,  390,  0,   1,  0);
    addVec(0,   0,  0,   1,   0,    1,  390,  0,   0,  0);

    #2 reset = 1'b1;
    #1 checkAll("async reset", 400, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;

    $display("[TB] running %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      for (int r = 0; r < vecs[i].reps; r++)
        applyStimulus(vecs[i].hit, vecs[i].dmg, vecs[i].heal, vecs[i].tick, vecs[i].start);
      checkAll($sformatf("vec%0d", i), vecs[i].expBlood, vecs[i].expDead,
               vecs[i].expInv, vecs[i].expFlash);
    end

    $display("[TB] regeneration sequence");
    applyStimulus(0, 8'd0, 0, 0, 1);
    applyStimulus(1, 8'd50, 0, 0, 0);
    checkOutput("regen start blood", int'(playerBlood), 350);
    for (int t = 1; t <= 150; t++) begin
      applyStimulus(0, 8'd0, 0, 1, 0);
      expBlood = (t <= 120) ? 350 : 350 + (t - 120) / 8;
      checkOutput($sformatf("regen tick%0d blood", t), int'(playerBlood), expBlood);
    end
    applyStimulus(1, 8'd1, 0, 1, 0);
    checkAll("hit on tick", 352, 1'b0, 1'b1, 1'b1);
    for (int t = 1; t <= 127; t++) applyStimulus(0, 8'd0, 0, 1, 0);
    checkAll("delay restarted t127", 352, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 8'd0, 0, 1, 0);
    checkOutput("delay restarted t128 blood", int'(playerBlood), 353);

    $display("[TB] async reset mid-HURT");
    applyStimulus(0, 8'd0, 0, 0, 1);
    applyStimulus(1, 8'd10, 0, 0, 0);
    for (int t = 1; t <= 18; t++) applyStimulus(0, 8'd0, 0, 1, 0);
    checkAll("inv12 before reset", 390, 1'b0, 1'b1, 1'b1);
    #3 reset = 1'b1;
    #1 checkAll("reset mid-HURT", 400, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    applyStimulus(1, 8'd100, 0, 0, 0);
    checkAll("hit after reset", 300, 1'b0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/player_health.md
# player_health

Owns the player's health value that the HUD blood bar renders. It applies zombie-contact damage, health pickups and timed regeneration, enforces a post-hit invulnerability window, and declares death. It runs in the `Clk` domain and is stepped by a one-cycle frame tick. `Player_Blood` drives the blood-bar renderer directly, which draws a bar `Player_Blood[9:1]` pixels wide.

## Interface
Parameters:
- `MaxBlood`, 400: full health, ≤1023; 400 gives a 200-px bar.
- `InvFrames`, 30: invulnerability length in frames after a non-fatal hit.
- `RegenDelay`, 120: frames without damage before regeneration starts.
- `RegenPeriod`, 8: frames between regeneration steps.
- `RegenStep`, 1: health added per regeneration step.
- `HealAmount`, 100: health added per pickup.

Ports:
- `Clk` in 1: system clock.
- `Reset` in 1: asynchronous, active-high.
- `Frame_Tick` in 1: one-`Clk` pulse per video frame.
- `Game_Start` in 1: synchronous restart pulse.
- `Hit` in 1: one-`Clk` damage request.
- `Hit_Damage` in 8: damage amount, sampled when `Hit`=1.
- `Heal` in 1: one-`Clk` pickup pulse.
- `Player_Blood` out 10: current health, 0..`MaxBlood`.
- `Is_Dead` out 1: high in DEAD.
- `Invincible` out 1: high in HURT.
- `Hurt_Flash` out 1: blink enable for the player sprite.

## Operation
- FSM states: ALIVE, HURT, DEAD.
- Registers:
  - `blood` (10 b).
  - `inv_cnt` (≥5 b, sized to `InvFrames`).
  - `quiet_cnt`: frames since the last hit, saturating at `RegenDelay`.
  - `regen_cnt`: counts 0..`RegenPeriod`-1.
- Priority, highest first: `Reset` > `Game_Start` > `Hit` > `Heal` > regeneration.
- `Reset` or `Game_Start`: `blood`=`MaxBlood`, state ALIVE, all counters 0.
- `Hit` in ALIVE:
  - Compute `blood` − `Hit_Damage` (zero-extended to 11 b) and saturate at 0.
  - Result 0 → DEAD.
  - Result >0 → HURT with `inv_cnt`=`InvFrames`.
  - In both cases `quiet_cnt`=0 and `regen_cnt`=0.
- `Hit` in HURT or DEAD: ignored entirely, including the counters.
- `Heal` in ALIVE or HURT: `blood` = min(`blood`+`HealAmount`, `MaxBlood`), computed in 11 b. Ignored in DEAD.
- `Hit` and `Heal` in the same cycle in ALIVE:
  - The hit applies first.
  - If the hit is fatal, the heal is discarded.
  - Otherwise the result is min(`blood`−dmg+`HealAmount`, `MaxBlood`) and the state goes to HURT.
- HURT, on each `Frame_Tick`:
  - `inv_cnt` decrements.
  - On the tick where `inv_cnt`=1, go to ALIVE with `inv_cnt`=0.
- `quiet_cnt` increments on `Frame_Tick` in ALIVE and HURT, saturating at `RegenDelay`.
- Regeneration, ALIVE only, when `quiet_cnt`=`RegenDelay`:
  - Each `Frame_Tick` increments `regen_cnt`.
  - When `regen_cnt` wraps from `RegenPeriod`-1 to 0, `blood` = min(`blood`+`RegenStep`, `MaxBlood`).
  - At `MaxBlood`, `regen_cnt` keeps cycling and `blood` stays saturated.
- `Frame_Tick` in the same cycle as an accepted `Hit`: the hit wins; counters clear and no decrement or regeneration happens that cycle.
- DEAD is absorbing until `Reset` or `Game_Start`. In DEAD, `blood`=0 and the counters are frozen.
- Outputs:
  - `Is_Dead` = (state==DEAD).
  - `Invincible` = (state==HURT).
  - `Hurt_Flash` = (state==HURT) & `inv_cnt[2]`.
  - All are decoded from registers only; no input-to-output combinational path.

## Timing
- `Reset` asserted → immediately `Player_Blood`=`MaxBlood`, `Is_Dead`=0, `Invincible`=0, `Hurt_Flash`=0.
- Every event (`Hit`, `Heal`, `Game_Start`, `Frame_Tick`) takes effect on the `Clk` edge where it is high. Outputs show the new value the cycle after, so latency is 1 cycle.
- `Game_Start` mid-HURT or in DEAD: restored values appear 1 cycle later, and that cycle's `Hit` is discarded.
- Inputs held high for multiple cycles count once per cycle. Upstream is responsible for delivering one-cycle pulses.
- Invulnerability lasts exactly `InvFrames` `Frame_Tick`s after the hit edge.

## Test plan
- Reset with default params → `Player_Blood`=400, `Is_Dead`=0. Then `Hit`, dmg=50 → next cycle `Player_Blood`=350, `Invincible`=1.
- From 350 in HURT: `Hit` dmg=200 → ignored, stays 350. After 30 `Frame_Tick`s → `Invincible`=0; 29 ticks → still 1.
- From 30 in ALIVE: `Hit` dmg=255 → `Player_Blood`=0, `Is_Dead`=1. Then `Heal` → stays 0. Then `Game_Start` → 400, `Is_Dead`=0.
- From 380: `Heal` → 400 (saturates). From 100: same-cycle `Hit` dmg=40 and `Heal` → 160, HURT. From 40: same-cycle `Hit` dmg=40 and `Heal` → 0, DEAD.
- From 350 after a hit: run 150 `Frame_Tick`s with no hits.
  - `Player_Blood` stays 350 through tick 120.
  - It becomes 351 at tick 128 and 352 at tick 136.
  - A `Hit` coincident with a tick resets the delay.
- Assert `Reset` mid-HURT with `inv_cnt`=12 → outputs return to reset values with no clock edge needed; `Hurt_Flash`=0.
